// File: rtl/rv32m_pkg.sv
// Purpose: shared encodings and constants for the RV32M multiply/divide unit.
// Latency: n/a (types, constants and pure helper functions only).
// Backpressure: n/a.
package rv32m_pkg;

  typedef enum logic [2:0] {
    OP_MUL    = 3'b000,
    OP_MULH   = 3'b001,
    OP_MULHSU = 3'b010,
    OP_MULHU  = 3'b011,
    OP_DIV    = 3'b100,
    OP_DIVU   = 3'b101,
    OP_REM    = 3'b110,
    OP_REMU   = 3'b111
  } op_e;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    RUN     = 2'd1,
    DONE_ST = 2'd2
  } state_e;

  localparam logic [31:0] DIV0_QUOTIENT = 32'hFFFF_FFFF;
  localparam logic [31:0] INT_MIN       = 32'h8000_0000;
  localparam int          ITER_COUNT    = 32;

  // rs1 is treated as two's complement for every signed op, including MULHSU.
  function automatic logic op_a_signed(input logic [2:0] op);
    case (op)
      OP_MUL, OP_MULH, OP_MULHSU, OP_DIV, OP_REM: op_a_signed = 1'b1;
      default:                                    op_a_signed = 1'b0;
    endcase
  endfunction

  // rs2 is unsigned for MULHSU and the unsigned ops.
  function automatic logic op_b_signed(input logic [2:0] op);
    case (op)
      OP_MUL, OP_MULH, OP_DIV, OP_REM: op_b_signed = 1'b1;
      default:                         op_b_signed = 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/ex_muldiv_unit_if.sv
// Purpose: EX-stage request/result bundle between the ID/EX register and the mul/div unit.
// Latency: n/a (wires only).
// Backpressure: BUSY from the unit freezes the ID/EX register, which holds START/OP/operands.
interface ex_muldiv_unit_if #(parameter int XLEN = 32);
  logic            START;
  logic [2:0]      OP;
  logic [XLEN-1:0] OPERAND_A;
  logic [XLEN-1:0] OPERAND_B;
  logic [XLEN-1:0] RESULT;
  logic            DONE;
  logic            BUSY;

  modport master (output START, OP, OPERAND_A, OPERAND_B, input RESULT, DONE, BUSY);
  modport slave  (input START, OP, OPERAND_A, OPERAND_B, output RESULT, DONE, BUSY);
endinterface

// File: rtl/muldiv_datapath.sv
// Purpose: magnitude conversion, 64-bit shift register with shared 33-bit add/sub step, sign fix-up.
// Latency: one iteration per step cycle; res is valid combinationally from the current step.
// Backpressure: none; sequenced entirely by load/step from the controlling FSM.
module muldiv_datapath
  import rv32m_pkg::*;
(
  input  logic        CLK,
  input  logic        RESET,
  input  logic        load,
  input  logic        step,
  input  logic [2:0]  op,
  input  logic [31:0] a,
  input  logic [31:0] b,
  input  logic [2:0]  op_q,
  input  logic        neg_q,
  output logic        neg,
  output logic [31:0] res
);

  logic        a_neg, b_neg;
  logic [31:0] mag_a, mag_b;
  logic [63:0] sr_d, sr_q, sr_step;
  logic [31:0] dvs_d, dvs_q;
  logic        is_div;
  logic [32:0] lhs, addend, sum;
  logic [63:0] prod_fix;
  logic [31:0] quo_fix, rem_fix;

  // Operand magnitudes and the single result-sign flag (REM follows rs1, others follow sign difference).
  always_comb begin
    a_neg = op_a_signed(op) & a[31];
    b_neg = op_b_signed(op) & b[31];
    mag_a = a_neg ? (~a + 32'd1) : a;
    mag_b = b_neg ? (~b + 32'd1) : b;
    neg   = (op == OP_REM) ? a_neg : (a_neg ^ b_neg);
  end

  // One iteration: multiply adds the multiplicand into the high half then shifts right;
  // divide shifts the remainder/quotient pair left and subtracts if it does not borrow.
  always_comb begin
    is_div  = op_q[2];
    lhs     = is_div ? {sr_q[63:32], sr_q[31]} : {1'b0, sr_q[63:32]};
    addend  = is_div ? ~{1'b0, dvs_q} : (sr_q[0] ? {1'b0, dvs_q} : 33'd0);
    sum     = lhs + addend + {32'd0, is_div};
    if (is_div) begin
      sr_step = sum[32] ? {lhs[31:0], sr_q[30:0], 1'b0} : {sum[31:0], sr_q[30:0], 1'b1};
    end else begin
      sr_step = {sum, sr_q[31:1]};
    end
    sr_d  = sr_q;
    dvs_d = dvs_q;
    if (load) begin
      sr_d  = {32'd0, mag_a};
      dvs_d = mag_b;
    end else if (step) begin
      sr_d  = sr_step;
    end
  end

  // Final sign correction, taken from the step output so the last iteration feeds RESULT directly.
  always_comb begin
    prod_fix = neg_q ? (~sr_step + 64'd1) : sr_step;
    quo_fix  = neg_q ? (~sr_step[31:0] + 32'd1) : sr_step[31:0];
    rem_fix  = neg_q ? (~sr_step[63:32] + 32'd1) : sr_step[63:32];
    case (op_q)
      OP_MUL:                      res = prod_fix[31:0];
      OP_MULH, OP_MULHSU, OP_MULHU: res = prod_fix[63:32];
      OP_DIV, OP_DIVU:             res = quo_fix;
      default:                     res = rem_fix;
    endcase
  end

  // Shift register and divisor/multiplicand hold.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      sr_q  <= '0;
      dvs_q <= '0;
    end else begin
      sr_q  <= sr_d;
      dvs_q <= dvs_d;
    end
  end

endmodule

// File: rtl/ex_muldiv_unit.sv
// Purpose: RV32M mul/div in EX; FSM, iteration count, special cases, DONE/RESULT registers. Option: MULDIV_FAST_MUL_EN.
// Latency: 33 cycles iterative (DONE at T33); 1 cycle for B=0, DIV/REM overflow, or fast multiply.
// Backpressure: BUSY = START && state!=DONE_ST stalls the front end until the result cycle.
module ex_muldiv_unit
  import rv32m_pkg::*;
#(
  parameter int XLEN = 32
) (
  input  logic           CLK,
  input  logic           RESET,
  ex_muldiv_unit_if.slave bus
);

  state_e          state_d, state_q;
  logic [4:0]      cnt_d, cnt_q;
  logic [2:0]      op_d, op_q;
  logic            neg_d, neg_q;
  logic [XLEN-1:0] result_d, result_q;
  logic            done_d, done_q;
  logic            load, step;
  logic            dp_neg;
  logic [31:0]     dp_res;
  logic            special_vld;
  logic [31:0]     special_res;
  logic            fast_vld;
  logic [31:0]     fast_res;

  muldiv_datapath u_dp (
    .CLK   (CLK),
    .RESET (RESET),
    .load  (load),
    .step  (step),
    .op    (bus.OP),
    .a     (bus.OPERAND_A),
    .b     (bus.OPERAND_B),
    .op_q  (op_q),
    .neg_q (neg_q),
    .neg   (dp_neg),
    .res   (dp_res)
  );

  // Divide-by-zero and signed overflow bypass the iteration entirely.
  always_comb begin
    special_vld = 1'b0;
    special_res = '0;
    if (bus.OP[2]) begin
      if (bus.OPERAND_B == 32'd0) begin
        special_vld = 1'b1;
        special_res = bus.OP[1] ? bus.OPERAND_A : DIV0_QUOTIENT;
      end else if (!bus.OP[0] && bus.OPERAND_A == INT_MIN && bus.OPERAND_B == 32'hFFFF_FFFF) begin
        special_vld = 1'b1;
        special_res = bus.OP[1] ? 32'd0 : INT_MIN;
      end
    end
  end

`ifdef MULDIV_FAST_MUL_EN
  logic signed [63:0] fast_a, fast_b, fast_p;

  // Single-cycle 33x33 signed product; operands sign- or zero-extended per op.
  always_comb begin
    fast_a   = {{32{op_a_signed(bus.OP) & bus.OPERAND_A[31]}}, bus.OPERAND_A};
    fast_b   = {{32{op_b_signed(bus.OP) & bus.OPERAND_B[31]}}, bus.OPERAND_B};
    fast_p   = fast_a * fast_b;
    fast_vld = !bus.OP[2];
    fast_res = (bus.OP == OP_MUL) ? fast_p[31:0] : fast_p[63:32];
  end
`else
  // Multiplies take the iterative path in this build.
  always_comb begin
    fast_vld = 1'b0;
    fast_res = '0;
  end
`endif

  // Next-state, counter and result selection.
  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    op_d     = op_q;
    neg_d    = neg_q;
    result_d = result_q;
    load     = 1'b0;
    step     = 1'b0;
    case (state_q)
      IDLE: begin
        if (bus.START) begin
          op_d  = bus.OP;
          neg_d = dp_neg;
          if (special_vld) begin
            result_d = special_res;
            state_d  = DONE_ST;
          end else if (fast_vld) begin
            result_d = fast_res;
            state_d  = DONE_ST;
          end else begin
            load    = 1'b1;
            cnt_d   = 5'd0;
            state_d = RUN;
          end
        end
      end
      RUN: begin
        step  = 1'b1;
        cnt_d = cnt_q + 5'd1;
        if (cnt_q == 5'(ITER_COUNT - 1)) begin
          result_d = dp_res;
          state_d  = DONE_ST;
        end
      end
      DONE_ST: state_d = IDLE;
      default: state_d = IDLE;
    endcase
    done_d = (state_d == DONE_ST);
  end

  // State and output registers; reset discards any op in flight.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      op_q     <= '0;
      neg_q    <= 1'b0;
      result_q <= '0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      op_q     <= op_d;
      neg_q    <= neg_d;
      result_q <= result_d;
      done_q   <= done_d;
    end
  end

  assign bus.BUSY   = bus.START && (state_q != DONE_ST);
  assign bus.RESULT = result_q;
  assign bus.DONE   = done_q;

endmodule

// File: tb/tb_ex_muldiv_unit.sv
module tb_ex_muldiv_unit;
  import rv32m_pkg::*;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  ex_muldiv_unit_if bus ();

  ex_muldiv_unit dut (
    .CLK   (clk),
    .RESET (rst),
    .bus   (bus)
  );

  int tests = 0;
  int fails = 0;
  int cyc_now = 0;
  always @(posedge clk) cyc_now++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  // RV32M semantics written directly from the ISA rules.
  function automatic logic [31:0] ref_model(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    int          ia, ib;
    longint      sp;
    logic [63:0] up;
    ia = a;
    ib = b;
    ref_model = '0;
    case (op)
      3'b000: begin sp = longint'(ia) * longint'(ib); up = sp; ref_model = up[31:0]; end
      3'b001: begin sp = longint'(ia) * longint'(ib); up = sp; ref_model = up[63:32]; end
      3'b010: begin sp = longint'(ia) * longint'({32'd0, b}); up = sp; ref_model = up[63:32]; end
      3'b011: begin up = {32'd0, a} * {32'd0, b}; ref_model = up[63:32]; end
      3'b100: begin
        if (b == 0) ref_model = 32'hFFFF_FFFF;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ref_model = 32'h8000_0000;
        else ref_model = ia / ib;
      end
      3'b101: ref_model = (b == 0) ? 32'hFFFF_FFFF : a / b;
      3'b110: begin
        if (b == 0) ref_model = a;
        else if (a == 32'h8000_0000 && b == 32'hFFFF_FFFF) ref_model = 32'd0;
        else ref_model = ia % ib;
      end
      default: ref_model = (b == 0) ? a : a % b;
    endcase
  endfunction

  // Cycles from START capture to DONE (also the BUSY-high count).
  function automatic int exp_lat(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b);
    if (!op[2]) begin
`ifdef MULDIV_FAST_MUL_EN
      return 1;
`else
      return 33;
`endif
    end
    if (b == 0) return 1;
    if (!op[0] && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) return 1;
    return 33;
  endfunction

  int done_cyc;

  // Issue one op at the next falling edge, hold it until DONE, count BUSY cycles.
  task automatic do_op(input logic [2:0] op, input logic [31:0] a, input logic [31:0] b,
                       input logic [31:0] exp, input bit scramble);
    int lat;
    int busy_n;
    bit seen;
    @(negedge clk);
    bus.START = 1'b1;
    bus.OP = op;
    bus.OPERAND_A = a;
    bus.OPERAND_B = b;
    lat = 0;
    busy_n = 0;
    seen = 1'b0;
    while (!seen && lat < 60) begin
      #1;
      if (bus.BUSY === 1'b1) busy_n++;
      @(negedge clk);
      lat++;
      if (scramble) begin
        bus.OPERAND_A = $urandom;
        bus.OPERAND_B = $urandom;
      end
      if (bus.DONE === 1'b1) seen = 1'b1;
    end
    done_cyc = cyc_now;
    check($sformatf("result op%0d a=%h b=%h", op, a, b), bus.RESULT, exp);
    check($sformatf("done_latency op%0d", op), 32'(lat), 32'(exp_lat(op, a, b)));
    check($sformatf("busy_cycles op%0d", op), 32'(busy_n), 32'(exp_lat(op, a, b)));
    check("busy_low_in_done", {31'd0, bus.BUSY}, 32'd0);
  endtask

  logic [31:0] corner [5];
  logic [31:0] ra, rb;
  logic [2:0]  rop;
  int          d0;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    corner[0] = 32'd0;
    corner[1] = 32'd1;
    corner[2] = 32'hFFFF_FFFF;
    corner[3] = 32'h8000_0000;
    corner[4] = 32'h7FFF_FFFF;

    // Reset state; BUSY follows START and RESET dominates it.
    rst = 1'b1;
    bus.START = 1'b0;
    bus.OP = 3'd0;
    bus.OPERAND_A = 32'd0;
    bus.OPERAND_B = 32'd0;
    repeat (3) @(negedge clk);
    check("reset_done", {31'd0, bus.DONE}, 32'd0);
    check("reset_result", bus.RESULT, 32'd0);
    check("reset_busy", {31'd0, bus.BUSY}, 32'd0);
    bus.START = 1'b1;
    bus.OPERAND_B = 32'd0;
    bus.OP = 3'b101;
    #1;
    check("reset_busy_follows_start", {31'd0, bus.BUSY}, 32'd1);
    @(negedge clk);
    check("reset_dominates_start", {31'd0, bus.DONE}, 32'd0);
    bus.START = 1'b0;
    rst = 1'b0;

    // Idle with START low: nothing happens.
    repeat (3) @(negedge clk);
    check("idle_done_low", {31'd0, bus.DONE}, 32'd0);
    check("idle_result_held", bus.RESULT, 32'd0);

    // Directed cases with hand-derived results.
    do_op(3'b000, 32'd7, 32'hFFFF_FFFD, 32'hFFFF_FFEB, 1'b0);
    do_op(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFE, 1'b0);
    do_op(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
    do_op(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 1'b0);
    do_op(3'b100, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFD, 1'b0);
    do_op(3'b110, 32'hFFFF_FFF9, 32'd2, 32'hFFFF_FFFF, 1'b0);
    do_op(3'b101, 32'hFFFF_FFF9, 32'd2, 32'h7FFF_FFFC, 1'b0);
    do_op(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1'b0);
    do_op(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 1'b0);
    do_op(3'b101, 32'h1234_5678, 32'd0, 32'hFFFF_FFFF, 1'b0);
    do_op(3'b111, 32'h1234_5678, 32'd0, 32'h1234_5678, 1'b0);
    @(negedge clk);
    bus.START = 1'b0;
    #1;
    check("done_single_cycle", {31'd0, bus.DONE}, 32'd0);

    // Abort DIVU 100/7 with a RESET pulse ten cycles in.
    @(negedge clk);
    bus.START = 1'b1;
    bus.OP = 3'b101;
    bus.OPERAND_A = 32'd100;
    bus.OPERAND_B = 32'd7;
    repeat (10) @(negedge clk);
    check("midrun_done_low", {31'd0, bus.DONE}, 32'd0);
    check("midrun_result_held", bus.RESULT, 32'h1234_5678);
    rst = 1'b1;
    @(negedge clk);
    check("abort_done", {31'd0, bus.DONE}, 32'd0);
    check("abort_result", bus.RESULT, 32'd0);
    rst = 1'b0;
    bus.START = 1'b0;

    // Re-issue, then REMU back to back with no idle gap.
    do_op(3'b101, 32'd100, 32'd7, 32'd14, 1'b0);
    d0 = done_cyc;
    do_op(3'b111, 32'd100, 32'd7, 32'd2, 1'b0);
    check("back_to_back_gap", 32'(done_cyc - d0), 32'd34);

    // Randomised back-to-back ops against the reference model; operands scrambled after capture.
    for (int i = 0; i < 40; i++) begin
      rop = 3'($urandom_range(0, 7));
      ra = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      rb = ($urandom_range(0, 3) == 0) ? corner[$urandom_range(0, 4)] : $urandom;
      if ($urandom_range(0, 7) == 0) rb = 32'($urandom_range(1, 15));
      do_op(rop, ra, rb, ref_model(rop, ra, rb), 1'b1);
    end
    @(negedge clk);
    bus.START = 1'b0;
    repeat (2) @(negedge clk);
    check("final_idle_done_low", {31'd0, bus.DONE}, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
